// File: rtl/varint_pkg.sv
// Shared definitions for the LEB128 varint encoder: FSM state encodings,
// byte-group constants and the two small helpers used by the datapath.
package varint_pkg;

    localparam logic [3:0] ST_IDLE  = 4'b0001;
    localparam logic [3:0] ST_EMIT  = 4'b0010;
    localparam logic [3:0] ST_PUSH  = 4'b0100;
    localparam logic [3:0] ST_FLUSH = 4'b1000;

    localparam logic [7:0] LEB_CONT = 8'h80;
    localparam int         GROUP_W  = 7;
    localparam int         LANES    = 4;
    localparam int         CNT_W    = 3;

    // One LEB128 output byte taken from the low group of the remaining value.
    function automatic logic [7:0] leb_byte(input logic [31:0] rem);
        logic [7:0] b;
        b = {1'b0, rem[GROUP_W-1:0]};
        if (rem > 32'h7F) begin
            b = b | LEB_CONT;
        end
        return b;
    endfunction

    function automatic logic [LANES-1:0] lane_mask(input logic [CNT_W-1:0] cnt);
        logic [LANES:0] m;
        m = ((LANES+1)'(1) << cnt) - (LANES+1)'(1);
        return m[LANES-1:0];
    endfunction

endpackage

// File: rtl/varint_byte_packer.sv
// Collects encoded bytes little-endian into the next free lane of a 32-bit word;
// clear empties the word once it has been pushed downstream.
module varint_byte_packer
    import varint_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en_i,
    input  logic [7:0]         byte_i,
    input  logic               clear_i,
    output logic [8*LANES-1:0] word_o,
    output logic [CNT_W-1:0]   cnt_o
);

    logic [LANES-1:0][7:0] lane_q, lane_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    // NOTE: every next-state signal gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        lane_d = lane_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            lane_d = '0;
            cnt_d  = '0;
        end else if (wr_en_i) begin
            lane_d[cnt_q[CNT_W-2:0]] = byte_i;
            cnt_d                    = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: the lane array is reset too, so lanes beyond the count always read as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q <= '0;
            cnt_q  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all flops update together.
            lane_q <= lane_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word_o = lane_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/varint_encoder.sv
// Drains 32-bit values from the input FIFO, LEB128-encodes them one byte per clock
// and pushes the packed little-endian words (with lane strobes) to the output FIFO.
module varint_encoder
    import varint_pkg::*;
#(
    parameter int OUT_W = 32,
    parameter int IDX_W = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               varint_in_fifo_empty,
    input  logic [31:0]        varint_in_fifo_rdata,
    input  logic [IDX_W-1:0]   varint_in_index_rdata,
    output logic               varint_in_fifo_pop,
    output logic               varint_in_index_pop,
    input  logic               flush,
    input  logic               varint_out_fifo_full,
    output logic               varint_out_fifo_push,
    output logic [OUT_W-1:0]   varint_out_fifo_wdata,
    output logic [OUT_W/8-1:0] varint_out_wstrb,
    output logic [IDX_W-1:0]   varint_out_index,
    output logic               busy
);

    logic [3:0]         state_q, state_d;
    logic [31:0]        rem_q, rem_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               flush_q, flush_d;
    logic               flush_req;
    logic               pop, push, wr_en, clear;
    logic [OUT_W/8-1:0] wstrb;
    logic [CNT_W-1:0]   cnt;
    logic [7:0]         emit_byte;

    assign flush_req = flush_q | flush;
    assign emit_byte = leb_byte(rem_q);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        flush_d = flush_req;
        pop     = 1'b0;
        push    = 1'b0;
        wr_en   = 1'b0;
        clear   = 1'b0;
        wstrb   = '0;
        case (state_q)
            ST_IDLE: begin
                if (!varint_in_fifo_empty) begin
                    pop     = 1'b1;
                    rem_d   = varint_in_fifo_rdata;
                    idx_d   = varint_in_index_rdata;
                    state_d = ST_EMIT;
                end else if (flush_req) begin
                    // A flush with nothing buffered is dropped rather than kept pending.
                    flush_d = 1'b0;
                    if (cnt != '0) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_EMIT: begin
                wr_en = 1'b1;
                rem_d = rem_q >> GROUP_W;
                if (cnt == CNT_W'(LANES - 1)) begin
                    state_d = ST_PUSH;
                end else if (rem_q <= 32'h7F) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PUSH: begin
                wstrb = '1;
                if (!varint_out_fifo_full) begin
                    push  = 1'b1;
                    clear = 1'b1;
                    // The shifted remainder is zero exactly when the last group has gone out.
                    state_d = (rem_q != '0) ? ST_EMIT : ST_IDLE;
                end
            end
            ST_FLUSH: begin
                wstrb = lane_mask(cnt);
                if (!varint_out_fifo_full) begin
                    push    = 1'b1;
                    clear   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            idx_q   <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            flush_q <= flush_d;
        end
    end

    varint_byte_packer u_packer (
        .clk     (clk),
        .reset   (reset),
        .wr_en_i (wr_en),
        .byte_i  (emit_byte),
        .clear_i (clear),
        .word_o  (varint_out_fifo_wdata),
        .cnt_o   (cnt)
    );

    assign varint_in_fifo_pop   = pop & ~reset;
    assign varint_in_index_pop  = pop & ~reset;
    assign varint_out_fifo_push = push & ~reset;
    assign varint_out_wstrb     = wstrb;
    assign varint_out_index     = idx_q;
    assign busy                 = (state_q != ST_IDLE) || (cnt != '0);

endmodule

// File: tb/tb_varint_encoder.sv
// Self-checking bench for varint_encoder: boundary vector table, directed stall/reset/flush
// sequences, and random batches against a byte-stream LEB128 reference model.
module tb_varint_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        empty;
    logic [31:0] rdata;
    logic [9:0]  irdata;
    logic        pop, ipop;
    logic        flush;
    logic        full;
    logic        push;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [9:0]  oidx;
    logic        busy;

    always #5 clk = ~clk;

    varint_encoder dut (
        .clk                   (clk),
        .reset                 (reset),
        .varint_in_fifo_empty  (empty),
        .varint_in_fifo_rdata  (rdata),
        .varint_in_index_rdata (irdata),
        .varint_in_fifo_pop    (pop),
        .varint_in_index_pop   (ipop),
        .flush                 (flush),
        .varint_out_fifo_full  (full),
        .varint_out_fifo_push  (push),
        .varint_out_fifo_wdata (wdata),
        .varint_out_wstrb      (wstrb),
        .varint_out_index      (oidx),
        .busy                  (busy)
    );

    typedef struct { logic [31:0] value; logic [9:0] idx; } in_t;
    typedef struct { logic [31:0] wdata; logic [3:0] wstrb; logic [9:0] idx; } word_t;
    typedef struct {
        logic [31:0] value;
        int          n_words;
        logic [31:0] w0;
        logic [3:0]  s0;
        logic [31:0] w1;
        logic [3:0]  s1;
    } vec_t;

    in_t        in_q[$];
    word_t      got_q[$];
    word_t      exp_q[$];
    logic [7:0] pend_b[$];
    logic [9:0] pend_i[$];

    int n_checks = 0;
    int n_pass   = 0;

    logic        s_push, s_pop, s_busy;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic [9:0]  s_idx;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // One clock: drive FIFO head, sample outputs on the falling edge, retire pops/pushes.
    task automatic tick();
        empty = (in_q.size() == 0);
        if (in_q.size() != 0) begin
            rdata  = in_q[0].value;
            irdata = in_q[0].idx;
        end
        @(negedge clk);
        s_push  = push;
        s_pop   = pop;
        s_busy  = busy;
        s_wdata = wdata;
        s_wstrb = wstrb;
        s_idx   = oidx;
        if (pop || ipop) check("pop_pair", 64'(ipop), 64'(pop));
        if (pop && in_q.size() != 0) void'(in_q.pop_front());
        if (push) begin
            check("push_while_full", 64'(full), 64'd0);
            got_q.push_back('{wdata, wstrb, oidx});
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget);
        for (int t = 0; t < budget && got_q.size() < n; t++) tick();
    endtask

    // Reference model: plain LEB128 byte stream, cut into 4-byte words.
    task automatic model_emit();
        word_t w;
        w.wdata = '0;
        w.wstrb = '0;
        w.idx   = '0;
        for (int k = 0; k < pend_b.size(); k++) begin
            w.wdata[8*k +: 8] = pend_b[k];
            w.wstrb[k]        = 1'b1;
            w.idx             = pend_i[k];
        end
        if (pend_b.size() != 0) exp_q.push_back(w);
        pend_b.delete();
        pend_i.delete();
    endtask

    task automatic model_value(input logic [31:0] v, input logic [9:0] idx);
        logic [31:0] r;
        logic [7:0]  b;
        r = v;
        do begin
            b = {1'b0, r[6:0]};
            r = r / 128;
            if (r != 0) b[7] = 1'b1;
            pend_b.push_back(b);
            pend_i.push_back(idx);
            if (pend_b.size() == 4) model_emit();
        end while (r != 0);
    endtask

    vec_t vec[11];

    initial begin : main
        int          nv, flush_at;
        bit          do_flush;
        logic [31:0] v;
        logic [9:0]  vi;

        vec[0]  = '{32'h0000_0000, 1, 32'h0000_0000, 4'b0001, 32'h0, 4'h0};
        vec[1]  = '{32'h0000_007F, 1, 32'h0000_007F, 4'b0001, 32'h0, 4'h0};
        vec[2]  = '{32'h0000_0080, 1, 32'h0000_0180, 4'b0011, 32'h0, 4'h0};
        vec[3]  = '{32'h0000_012C, 1, 32'h0000_02AC, 4'b0011, 32'h0, 4'h0};
        vec[4]  = '{32'h0000_3FFF, 1, 32'h0000_7FFF, 4'b0011, 32'h0, 4'h0};
        vec[5]  = '{32'h0000_4000, 1, 32'h0001_8080, 4'b0111, 32'h0, 4'h0};
        vec[6]  = '{32'h001F_FFFF, 1, 32'h007F_FFFF, 4'b0111, 32'h0, 4'h0};
        vec[7]  = '{32'h0020_0000, 1, 32'h0180_8080, 4'b1111, 32'h0, 4'h0};
        vec[8]  = '{32'h0FFF_FFFF, 1, 32'h7FFF_FFFF, 4'b1111, 32'h0, 4'h0};
        vec[9]  = '{32'h1000_0000, 2, 32'h8080_8080, 4'b1111, 32'h0000_0001, 4'b0001};
        vec[10] = '{32'hFFFF_FFFF, 2, 32'hFFFF_FFFF, 4'b1111, 32'h0000_000F, 4'b0001};

        reset = 1'b1; flush = 1'b0; full = 1'b0; empty = 1'b1; rdata = '0; irdata = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_push",  64'(s_push),  64'd0);
        check("rst_pop",   64'(s_pop),   64'd0);
        check("rst_wdata", 64'(s_wdata), 64'd0);
        check("rst_wstrb", 64'(s_wstrb), 64'd0);
        check("rst_index", 64'(s_idx),   64'd0);
        check("rst_busy",  64'(s_busy),  64'd0);

        // Single value then flush, covering every byte-count boundary.
        for (int i = 0; i < 11; i++) begin
            got_q.delete();
            in_q.push_back('{vec[i].value, 10'(i + 16)});
            tick();
            flush = 1'b1;
            tick();
            wait_words(vec[i].n_words, 40);
            repeat (4) tick();
            check($sformatf("vec%0d_nwords", i), 64'(got_q.size()), 64'(vec[i].n_words));
            if (got_q.size() >= 1) begin
                check($sformatf("vec%0d_w0", i),   64'(got_q[0].wdata), 64'(vec[i].w0));
                check($sformatf("vec%0d_s0", i),   64'(got_q[0].wstrb), 64'(vec[i].s0));
                check($sformatf("vec%0d_idx0", i), 64'(got_q[0].idx),   64'(i + 16));
            end
            if (vec[i].n_words == 2 && got_q.size() >= 2) begin
                check($sformatf("vec%0d_w1", i), 64'(got_q[1].wdata), 64'(vec[i].w1));
                check($sformatf("vec%0d_s1", i), 64'(got_q[1].wstrb), 64'(vec[i].s1));
            end
        end

        // Four single-byte values fill exactly one word without a flush.
        got_q.delete();
        for (int k = 0; k < 4; k++) in_q.push_back('{32'(k + 1), 10'(k + 11)});
        wait_words(1, 30);
        repeat (3) tick();
        check("pack4_nwords", 64'(got_q.size()), 64'd1);
        if (got_q.size() >= 1) begin
            check("pack4_wdata", 64'(got_q[0].wdata), 64'h0403_0201);
            check("pack4_wstrb", 64'(got_q[0].wstrb), 64'hF);
            check("pack4_index", 64'(got_q[0].idx),   64'd14);
        end
        check("pack4_idle_busy", 64'(s_busy), 64'd0);

        // Output FIFO full while a word waits: outputs hold, nothing pushed or popped.
        got_q.delete();
        full = 1'b1;
        for (int k = 0; k < 4; k++) in_q.push_back('{32'(k + 5), 10'(k + 100)});
        for (int t = 0; t < 20 && s_wstrb != 4'hF; t++) tick();
        check("stall_reach_push", 64'(s_wstrb), 64'hF);
        in_q.push_back('{32'd9, 10'd200});
        for (int t = 0; t < 10; t++) begin
            tick();
            check("stall_wdata", 64'(s_wdata), 64'h0807_0605);
            check("stall_wstrb", 64'(s_wstrb), 64'hF);
            check("stall_push",  64'(s_push),  64'd0);
            check("stall_pop",   64'(s_pop),   64'd0);
        end
        full = 1'b0;
        tick();
        check("stall_release_push", 64'(s_push), 64'd1);
        check("stall_release_idx",  64'(s_idx),  64'd103);
        tick();
        flush = 1'b1;
        tick();
        wait_words(2, 20);
        repeat (3) tick();
        check("stall_nwords", 64'(got_q.size()), 64'd2);
        if (got_q.size() >= 2) begin
            check("stall_tail_wdata", 64'(got_q[1].wdata), 64'h0000_0009);
            check("stall_tail_wstrb", 64'(got_q[1].wstrb), 64'b0001);
            check("stall_tail_idx",   64'(got_q[1].idx),   64'd200);
        end

        // Flush with no buffered bytes is ignored; value 0 then flush gives one 0x00 lane.
        got_q.delete();
        flush = 1'b1;
        repeat (6) tick();
        check("empty_flush_nwords", 64'(got_q.size()), 64'd0);
        in_q.push_back('{32'd0, 10'd5});
        tick();
        flush = 1'b1;
        tick();
        wait_words(1, 20);
        repeat (3) tick();
        check("zero_flush_nwords", 64'(got_q.size()), 64'd1);
        if (got_q.size() >= 1) begin
            check("zero_flush_wdata", 64'(got_q[0].wdata), 64'h0);
            check("zero_flush_wstrb", 64'(got_q[0].wstrb), 64'b0001);
        end

        // Flush together with a waiting value: the pop goes first, the flush follows.
        got_q.delete();
        in_q.push_back('{32'd5, 10'd1});
        repeat (4) tick();
        in_q.push_back('{32'd6, 10'd2});
        flush = 1'b1;
        tick();
        wait_words(1, 20);
        repeat (3) tick();
        check("pop_wins_nwords", 64'(got_q.size()), 64'd1);
        if (got_q.size() >= 1) begin
            check("pop_wins_wdata", 64'(got_q[0].wdata), 64'h0000_0605);
            check("pop_wins_wstrb", 64'(got_q[0].wstrb), 64'b0011);
            check("pop_wins_idx",   64'(got_q[0].idx),   64'd2);
        end

        // Reset in the middle of emitting a 5-byte value drops everything.
        got_q.delete();
        in_q.push_back('{32'h1000_0000, 10'd77});
        tick();
        tick();
        check("mid_emit_busy", 64'(s_busy), 64'd1);
        reset = 1'b1;
        in_q.push_back('{32'd1, 10'd1});
        tick();
        check("rst_cycle_push", 64'(s_push), 64'd0);
        check("rst_cycle_pop",  64'(s_pop),  64'd0);
        tick();
        check("post_rst_wdata", 64'(s_wdata), 64'd0);
        check("post_rst_wstrb", 64'(s_wstrb), 64'd0);
        check("post_rst_busy",  64'(s_busy),  64'd0);
        check("post_rst_index", 64'(s_idx),   64'd0);
        in_q.delete();
        reset = 1'b0;
        repeat (10) tick();
        check("post_rst_nwords", 64'(got_q.size()), 64'd0);

        // Random batches with back-pressure and optional flush, against the model.
        for (int b = 0; b < 12; b++) begin
            got_q.delete();
            exp_q.delete();
            nv = $urandom_range(1, 8);
            for (int k = 0; k < nv; k++) begin
                v  = $urandom() >> $urandom_range(0, 31);
                vi = 10'($urandom_range(0, 1023));
                in_q.push_back('{v, vi});
                model_value(v, vi);
            end
            do_flush = 1'($urandom_range(0, 1));
            flush_at = $urandom_range(0, 10);
            for (int t = 0; t < 300 && (in_q.size() != 0 || t <= flush_at); t++) begin
                full = ($urandom_range(0, 3) == 0);
                if (do_flush && t == flush_at) flush = 1'b1;
                tick();
            end
            full = 1'b0;
            if (do_flush) model_emit();
            wait_words(exp_q.size(), 100);
            repeat (6) tick();
            check($sformatf("rnd%0d_nwords", b), 64'(got_q.size()), 64'(exp_q.size()));
            for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
                check($sformatf("rnd%0d_w%0d_wdata", b, k), 64'(got_q[k].wdata), 64'(exp_q[k].wdata));
                check($sformatf("rnd%0d_w%0d_wstrb", b, k), 64'(got_q[k].wstrb), 64'(exp_q[k].wstrb));
                check($sformatf("rnd%0d_w%0d_idx", b, k),   64'(got_q[k].idx),   64'(exp_q[k].idx));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
